// File: rtl/cplx_pkg.sv
// Shared types and constants for the complex add/sub datapath.
// No logic; default width derives from N_DEF.
// Not applicable: pure declarations.
package cplx_pkg;
  localparam int N_DEF = 3;
  localparam int W = 2**N_DEF;
  localparam logic signed [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  function automatic int width_of(input int n);
    return 2**n;
  endfunction
endpackage

// File: rtl/sat_trunc.sv
// Narrows a signed W+1-bit value to W bits, flagging overflow; ADD_SUB_SAT_EN clamps, else wraps.
// Latency: combinational.
// Backpressure: none.
module sat_trunc #(
  parameter int W = 8
)(
  input  logic signed [W:0]   din,
  output logic signed [W-1:0] dout,
  output logic                ovf
);
  // Top two bits disagree exactly when the value does not fit in W bits.
  assign ovf = din[W] ^ din[W-1];

`ifdef ADD_SUB_SAT_EN
  localparam logic signed [W-1:0] LIM_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] LIM_NEG = {1'b1, {(W-1){1'b0}}};
  assign dout = !ovf ? din[W-1:0] : (din[W] ? LIM_NEG : LIM_POS);
`else
  assign dout = din[W-1:0];
`endif
endmodule

// File: rtl/cplx_add_sub_pipe.sv
// Radix-2 butterfly: A+B and A-B with optional /2, overflow flag and counter (ADD_SUB_SAT_EN selects clamp).
// Latency: 2 cycles, 1 transaction/cycle.
// Backpressure: in_ready is combinational from out_ready through both stall stages.
module cplx_add_sub_pipe
  import cplx_pkg::*;
#(
  parameter int N     = 3,
  parameter int CNT_W = 8,
  localparam int W    = width_of(N)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic                scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] sum_re,
  output logic signed [W-1:0] sum_im,
  output logic signed [W-1:0] dif_re,
  output logic signed [W-1:0] dif_im,
  output logic                ovf,
  output logic [CNT_W-1:0]    ovf_cnt,
  input  logic                cnt_clr
);
  logic              s1_vld, s2_vld, s1_adv, s2_adv;
  logic              s1_scale;
  logic signed [W:0] ext_dat [4];
  logic signed [W:0] s1_dat  [4];
  logic signed [W:0] scl_dat [4];
  logic signed [W-1:0] trn_dat [4];
  logic [3:0]        trn_ovf;

  assign s2_adv    = !s2_vld || out_ready;
  assign s1_adv    = !s1_vld || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_vld;

  // Index order throughout: sum_re, sum_im, dif_re, dif_im.
  always_comb begin
    ext_dat[0] = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    ext_dat[1] = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    ext_dat[2] = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    ext_dat[3] = {a_im[W-1], a_im} - {b_im[W-1], b_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_scale <= 1'b0;
      for (int i = 0; i < 4; i++) s1_dat[i] <= '0;
    end else if (s1_adv) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_scale <= scale;
        for (int i = 0; i < 4; i++) s1_dat[i] <= ext_dat[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      scl_dat[i] = s1_scale ? (s1_dat[i] >>> 1) : s1_dat[i];
  end

  for (genvar g = 0; g < 4; g++) begin : g_trn
    sat_trunc #(.W(W)) u_sat_trunc (
      .din  (scl_dat[g]),
      .dout (trn_dat[g]),
      .ovf  (trn_ovf[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
      sum_re <= '0;
      sum_im <= '0;
      dif_re <= '0;
      dif_im <= '0;
      ovf    <= 1'b0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        sum_re <= trn_dat[0];
        sum_im <= trn_dat[1];
        dif_re <= trn_dat[2];
        dif_im <= trn_dat[3];
        ovf    <= |trn_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_cnt <= '0;
    else if (cnt_clr)
      ovf_cnt <= '0;
    else if (s2_vld && out_ready && ovf && (ovf_cnt != {CNT_W{1'b1}}))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_cplx_add_sub_pipe.sv
// Scoreboard bench for cplx_add_sub_pipe (N=3, CNT_W=2): directed vectors, stalls, counter saturation, async reset.
module tb_cplx_add_sub_pipe;
  import cplx_pkg::*;

  localparam int CW = 2;
  localparam int CNT_MAX = 2**CW - 1;

`ifdef ADD_SUB_SAT_EN
  localparam logic signed [W-1:0] V_P200 = MAX_POS;
  localparam logic signed [W-1:0] V_M200 = MAX_NEG;
  localparam logic signed [W-1:0] V_P128 = MAX_POS;
`else
  localparam logic signed [W-1:0] V_P200 = -56;
  localparam logic signed [W-1:0] V_M200 = 56;
  localparam logic signed [W-1:0] V_P128 = -128;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, scale, out_valid, out_ready, ovf, cnt_clr;
  logic signed [W-1:0] a_re, a_im, b_re, b_im, sum_re, sum_im, dif_re, dif_im;
  logic [CW-1:0] ovf_cnt;

  typedef struct {
    cplx_t sum;
    cplx_t dif;
    logic  ovf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cplx_add_sub_pipe #(.N(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
    .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Monitor: pops one expectation per output handshake and tracks the counter.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output sum=(%0d,%0d) dif=(%0d,%0d)", sum_re, sum_im, dif_re, dif_im);
        end else begin
          e = q.pop_front();
          if (sum_re != e.sum.re || sum_im != e.sum.im || dif_re != e.dif.re ||
              dif_im != e.dif.im || ovf != e.ovf) begin
            bad++;
            $display("FAIL result got sum=(%0d,%0d) dif=(%0d,%0d) ovf=%0b required sum=(%0d,%0d) dif=(%0d,%0d) ovf=%0b",
                     sum_re, sum_im, dif_re, dif_im, ovf, e.sum.re, e.sum.im, e.dif.re, e.dif.im, e.ovf);
          end
          chk("ovf_cnt_at_hs", int'(ovf_cnt), exp_cnt);
          if (e.ovf && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
        end
      end
      if (cnt_clr) exp_cnt = 0;
    end
  end

  task automatic send(input logic signed [W-1:0] ar, ai, br, bi, input logic sc,
                      input logic signed [W-1:0] sr, si, dr, di, input logic ov);
    exp_t x;
    bit ok = 0;
    in_valid = 1'b1; a_re = ar; a_im = ai; b_re = br; b_im = bi; scale = sc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    x.sum.re = sr; x.sum.im = si; x.dif.re = dr; x.dif.im = di; x.ovf = ov;
    q.push_back(x);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ovf_cnt", int'(ovf_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic sum/difference with the latency check.
    send(5, 3, 2, 7, 0, 7, 10, 3, -4, 0);
    chk("lat1_early", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat1_valid", int'(out_valid), 1);
    send(100, 0, 100, 0, 0, V_P200, 0, 0, 0, 1);
    send(100, 0, 100, 0, 1, 100, 0, 0, 0, 0);
    send(-128, -1, 1, 0, 1, -64, -1, -65, -1, 0);
    send(-100, 0, 100, 0, 0, 0, 0, V_M200, 0, 1);
    send(0, 127, 0, -1, 0, 0, 126, 0, V_P128, 1);
    drain();
    chk("cnt_after_directed", int'(ovf_cnt), 3);

    // Backpressure: hold out_ready low until both stages fill.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(W'(k), 0, 0, 0, 0, W'(k), 0, W'(k), 0, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter clear, then saturation at 3.
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("cnt_clear", int'(ovf_cnt), 0);
    repeat (5) send(100, 0, 100, 0, 0, V_P200, 0, 0, 0, 1);
    drain();
    chk("cnt_saturate", int'(ovf_cnt), CNT_MAX);

    // Clear coincident with an overflowing handshake.
    out_ready = 1'b0;
    send(100, 0, 100, 0, 0, V_P200, 0, 0, 0, 1);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid) begin seen = 1; break; end
      end
      chk("stalled_out_seen", int'(seen), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("cnt_clr_priority", int'(ovf_cnt), 0);
    drain();

    // Async reset with both stages full.
    send(100, 0, 100, 0, 0, V_P200, 0, 0, 0, 1);
    drain();
    chk("cnt_before_rst", int'(ovf_cnt), 1);
    out_ready = 1'b0;
    send(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    send(2, 0, 0, 0, 0, 2, 0, 2, 0, 0);
    chk("full_before_rst", int'(in_ready), 0);
    #3 rst = 1'b1;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_ovf_cnt", int'(ovf_cnt), 0);
    chk("async_in_ready", int'(in_ready), 1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    send(9, 1, 2, 3, 0, 11, 4, 7, -2, 0);
    chk("lat2_early", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat2_valid", int'(out_valid), 1);
    drain();
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
